tt_um_serial_add_seq: RTL and testbench

Bit-serial 8-bit adder sequencer for the TinyTapeout tile. It holds two operand registers loaded from the dedicated inputs and drives the team's half-adder datapath (sum = a^b, carry = a&b) one bit per clock. Two half-adder evaluations per bit form a full add, and the carry is held in a flop between bits. Start/busy/done handshake is on the bidirectional pins; the result is read back on the dedicated outputs.

---
 rtl/tt_um_serial_add_seq_if.sv | 30 +++
 rtl/tt_um_serial_add_seq.sv | 116 +++++++++++
 tb/tb_tt_um_serial_add_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/tt_um_serial_add_seq_if.sv
// ---------------------------------------------------------------------------
// tt_um_serial_add_seq_if
// Pin bundle for the serial-add TinyTapeout tile. The pin names follow the
// standard tile pinout.
//   ena      : tile enable (always 1 when powered)
//   ui_in    : operand byte
//   uio_in   : control strobes [0] load_a, [1] load_b, [2] start, [3] sel_hi
//   uio_out  : status [4] busy, [5] done, [6] carry_out, [7] zero
//   uio_oe   : bidirectional output enables
//   uo_out   : result byte, or carry_out when sel_hi=1
// The master modport is the pad side. The slave modport is the sequencer.
// ---------------------------------------------------------------------------
interface tt_um_serial_add_seq_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    modport master (
        output ena, ui_in, uio_in,
        input  uio_out, uio_oe, uo_out
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uio_out, uio_oe, uo_out
    );
endinterface

// File: rtl/tt_um_serial_add_seq.sv
// ---------------------------------------------------------------------------
// tt_um_serial_add_seq
// Bit-serial 8-bit adder. It adds the two operand registers LSB first, one
// bit per clock. Each bit goes through two half-adder evaluations, and the
// carry is held in a flop between bits.
//   clk    : single clock domain
//   rst_n  : asynchronous, active-low reset
//   bus    : tile pins (see tt_um_serial_add_seq_if)
// A start rising edge, taken in IDLE or DONE, runs 8 busy cycles and then
// enters DONE. Result and carry hold in DONE until the next run completes.
// ---------------------------------------------------------------------------
module tt_um_serial_add_seq (
    input  logic                         clk,
    input  logic                         rst_n,
    tt_um_serial_add_seq_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_d;
    logic [7:0] op_a, op_b;
    logic [7:0] sh_a, sh_b;
    logic [7:0] sum_sh;
    logic       c;
    logic [2:0] cnt;
    logic       start_q;
    logic [7:0] result;
    logic       carry_out;

    logic load_a, load_b, start, sel_hi;
    assign load_a = bus.uio_in[0];
    assign load_b = bus.uio_in[1];
    assign start  = bus.uio_in[2];
    assign sel_hi = bus.uio_in[3];

    // ena and the upper control pins are don't-care inputs on this tile.
    logic unused;
    assign unused = ^{bus.ena, bus.uio_in[7:4]};

    logic start_rise, idle_or_done, go, last_bit;
    assign start_rise   = start & ~start_q;
    assign idle_or_done = (state != RUN);
    assign go           = start_rise & idle_or_done;
    assign last_bit     = (state == RUN) && (cnt == 3'd7);

    // Two chained half-adders form one full-adder bit.
    logic h1, g1, s, g2, c_next;
    assign h1     = sh_a[0] ^ sh_b[0];
    assign g1     = sh_a[0] & sh_b[0];
    assign s      = h1 ^ c;
    assign g2     = h1 & c;
    assign c_next = g1 | g2;

    // NOTE: every output of a combinational block is given a default first,
    // so that no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start_rise) state_d = RUN;
            RUN:     if (cnt == 3'd7) state_d = DONE;
            DONE:    if (start_rise) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    // On a start edge, sh_a and sh_b therefore copy the operands as they were
    // before that edge, even if a load writes the same register on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            sum_sh    <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            start_q   <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            start_q <= start;
            if (idle_or_done && load_a) op_a <= bus.ui_in;
            if (idle_or_done && load_b) op_b <= bus.ui_in;
            if (go) begin
                sh_a <= op_a;
                sh_b <= op_b;
                c    <= 1'b0;
                cnt  <= '0;
            end else if (state == RUN) begin
                sum_sh <= {s, sum_sh[7:1]};
                sh_a   <= {1'b0, sh_a[7:1]};
                sh_b   <= {1'b0, sh_b[7:1]};
                c      <= c_next;
                cnt    <= cnt + 3'd1;   // 7 wraps to 0 as DONE is entered
                if (last_bit) begin
                    result    <= {s, sum_sh[7:1]};
                    carry_out <= c_next;
                end
            end
        end
    end

    logic busy, done, zero;
    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign zero = done & (result == 8'h00) & ~carry_out;

    assign bus.uio_out = {zero, carry_out, done, busy, 4'b0000};
    assign bus.uio_oe  = 8'hF0;
    assign bus.uo_out  = sel_hi ? {7'b0, carry_out} : result;
endmodule

// File: tb/tb_tt_um_serial_add_seq.sv
module tb_tt_um_serial_add_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tt_um_serial_add_seq_if bus ();

    tt_um_serial_add_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
        logic       zero;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Advance one clock. Outputs are read 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        bus.ui_in = a; bus.uio_in = 8'h01; step();
        bus.ui_in = b; bus.uio_in = 8'h02; step();
        bus.uio_in = 8'h00;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.uio_out[5] && n < 20) begin
            step();
            n++;
        end
        check({name, "_done_timeout"}, 32'(bus.uio_out[5]), 32'd1);
    endtask

    // Pulse start, count busy cycles, then check the result and flags.
    task automatic run_check(input string name, input logic [7:0] sum,
                             input logic carry, input logic zero);
        int busy_cnt = 0;
        bus.uio_in = 8'h04; step();
        bus.uio_in = 8'h00;
        while (bus.uio_out[4] && busy_cnt < 20) begin
            busy_cnt++;
            step();
        end
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({name, "_done"},  32'(bus.uio_out[5]), 32'd1);
        check({name, "_sum"},   32'(bus.uo_out), 32'(sum));
        check({name, "_carry"}, 32'(bus.uio_out[6]), 32'(carry));
        check({name, "_zero"},  32'(bus.uio_out[7]), 32'(zero));
    endtask

    initial begin
        int busy_cnt;
        checks = 0;
        failures = 0;
        vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0};
        vecs[6] = '{8'h01, 8'hFF, 8'h00, 1'b1, 1'b0};

        bus.ena = 1'b1; bus.ui_in = 8'h00; bus.uio_in = 8'h00;
        rst_n = 1'b0;
        #12;
        check("rst_uo_out",  32'(bus.uo_out), 32'h00);
        check("rst_uio_out", 32'(bus.uio_out), 32'h00);
        check("rst_uio_oe",  32'(bus.uio_oe), 32'hF0);
        rst_n = 1'b1;
        step();
        check("idle_status", 32'(bus.uio_out), 32'h00);

        // Table-driven operations.
        foreach (vecs[i]) begin
            load(vecs[i].a, vecs[i].b);
            run_check($sformatf("vec%0d", i), vecs[i].sum, vecs[i].carry, vecs[i].zero);
            bus.uio_in = 8'h08; #1;
            check($sformatf("vec%0d_sel_hi", i), 32'(bus.uo_out), 32'(vecs[i].carry));
            check($sformatf("vec%0d_low_pins", i), 32'(bus.uio_out[3:0]), 32'h0);
            bus.uio_in = 8'h00;
        end

        // Holding start high from IDLE must give exactly one operation.
        rst_n = 1'b0; #2; rst_n = 1'b1;
        load(8'h01, 8'h02);
        busy_cnt = 0;
        bus.uio_in = 8'h04;
        for (int i = 0; i < 30; i++) begin
            if (bus.uio_out[4]) busy_cnt++;
            step();
        end
        check("hold_busy_cycles", 32'(busy_cnt), 32'd8);
        check("hold_done", 32'(bus.uio_out[5]), 32'd1);
        check("hold_sum",  32'(bus.uo_out), 32'h03);
        bus.uio_in = 8'h00;
        step();

        // A load during RUN is ignored.
        load(8'h10, 8'h20);
        bus.uio_in = 8'h04; step();
        bus.uio_in = 8'h01; bus.ui_in = 8'h77; step();
        bus.uio_in = 8'h00;
        wait_done("runload");
        check("runload_sum", 32'(bus.uo_out), 32'h30);
        run_check("runload_again", 8'h30, 1'b0, 1'b0);

        // Reset during RUN discards the partial result.
        load(8'h33, 8'h44);
        bus.uio_in = 8'h04; step();
        bus.uio_in = 8'h00;
        step(); step(); step();
        rst_n = 1'b0; #1;
        check("midrst_busy", 32'(bus.uio_out[4]), 32'd0);
        check("midrst_done", 32'(bus.uio_out[5]), 32'd0);
        check("midrst_uo",   32'(bus.uo_out), 32'h00);
        rst_n = 1'b1;
        step(); step();
        check("midrst_idle", 32'(bus.uio_out[4]), 32'd0);
        load(8'h80, 8'h80);
        run_check("postrst", 8'h00, 1'b1, 1'b0);

        // With start held through reset release, the first edge starts a run.
        bus.uio_in = 8'h04;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        step();
        check("startrst_busy", 32'(bus.uio_out[4]), 32'd1);
        bus.uio_in = 8'h00;
        wait_done("startrst");
        check("startrst_zero", 32'(bus.uio_out[7]), 32'd1);

        // load_b and start on the same edge: this run still uses the old B.
        load(8'h10, 8'h05);
        run_check("pre_same", 8'h15, 1'b0, 1'b0);
        bus.ui_in = 8'h01; bus.uio_in = 8'h06; step();
        bus.uio_in = 8'h00;
        check("same_busy", 32'(bus.uio_out[4]), 32'd1);
        check("same_prior_result", 32'(bus.uo_out), 32'h15);
        check("same_done_low", 32'(bus.uio_out[5]), 32'd0);
        wait_done("same");
        check("same_old_b", 32'(bus.uo_out), 32'h15);
        run_check("next_new_b", 8'h11, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
